regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters: requester A (ALU result) and requester B (load-unit result). Arbitrates round-robin with a valid/ready handshake and registers the winning write into a one-stage commit register that drives the register file's write port. Provides a read-bypass check on both register-file read addresses. Counts contention cycles for performance monitoring.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ADDR_W = 5;

  // Architectural zero register; writes to it are swallowed.
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-winner pointer.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  req_e last_q, last_d;

  // Lone requester wins; on a tie the one that did not win last time wins.
  always_comb begin
    gnt_o[0] = req_i[0] && (!req_i[1] || (last_q == REQ_B));
    gnt_o[1] = req_i[1] && (!req_i[0] || (last_q == REQ_A));
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = gnt_o[1] ? REQ_B : REQ_A;
    end
  end

  // Reset to B so A wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (A) and load unit (B).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_rd_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_rd_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              reg_write_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0] writedata_o,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              byp1_hit_o,
  output logic              byp2_hit_o,
  output logic [DATA_W-1:0] byp1_data_o,
  output logic [DATA_W-1:0] byp2_data_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  // Requests are masked during flush and while reset is held so no ready leaks out.
  always_comb begin
    req = {b_valid_i, a_valid_i} & {2{!flush_i && rst_ni}};
  end

  rr_arbiter2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .advance_i (|gnt),
    .gnt_o     (gnt)
  );

  assign a_ready_o = gnt[0];
  assign b_ready_o = gnt[1];

  // Next commit: the accepted write, with x0 writes collapsed to an all-zero bubble.
  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = '0;
    writedata_d = '0;
    if (gnt[0] && (a_rd_i != ZeroAddr)) begin
      reg_write_d = 1'b1;
      rd_d        = a_rd_i;
      writedata_d = a_data_i;
    end else if (gnt[1] && (b_rd_i != ZeroAddr)) begin
      reg_write_d = 1'b1;
      rd_d        = b_rd_i;
      writedata_d = b_data_i;
    end
  end

  // Saturating contention counter; counts raw valids, flush included.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (a_valid_i && b_valid_i && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // Commit register and counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_write_q    <= 1'b0;
      rd_q           <= '0;
      writedata_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      reg_write_q    <= reg_write_d;
      rd_q           <= rd_d;
      writedata_q    <= writedata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign reg_write_o    = reg_write_q;
  assign rd_o           = rd_q;
  assign writedata_o    = writedata_q;
  assign conflict_cnt_o = conflict_cnt_q;

  // Bypass the in-flight commit to both read ports.
  always_comb begin
    byp1_hit_o  = reg_write_q && (rs1_i == rd_q) && (rd_q != ZeroAddr);
    byp2_hit_o  = reg_write_q && (rs2_i == rd_q) && (rd_q != ZeroAddr);
    byp1_data_o = byp1_hit_o ? writedata_q : '0;
    byp2_data_o = byp2_hit_o ? writedata_q : '0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd, rs1, rs2, rd;
  logic [DW-1:0] a_data, b_data, writedata, byp1_data, byp2_data;
  logic          reg_write, byp1_hit, byp2_hit;
  logic [CW-1:0] conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .a_valid_i      (a_valid),
    .a_rd_i         (a_rd),
    .a_data_i       (a_data),
    .a_ready_o      (a_ready),
    .b_valid_i      (b_valid),
    .b_rd_i         (b_rd),
    .b_data_i       (b_data),
    .b_ready_o      (b_ready),
    .reg_write_o    (reg_write),
    .rd_o           (rd),
    .writedata_o    (writedata),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .byp1_hit_o     (byp1_hit),
    .byp2_hit_o     (byp2_hit),
    .byp1_data_o    (byp1_data),
    .byp2_data_o    (byp2_data),
    .conflict_cnt_o (conflict_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_commit(input string tag, input logic we, input logic [AW-1:0] r,
                              input logic [DW-1:0] d);
    check_val({tag, "_we"}, 64'(reg_write), 64'(we));
    check_val({tag, "_rd"}, 64'(rd), 64'(r));
    check_val({tag, "_wd"}, writedata, d);
  endtask

  task automatic idle_inputs();
    flush   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_rd    = '0;
    b_rd    = '0;
    a_data  = '0;
    b_data  = '0;
    rs1     = '0;
    rs2     = '0;
  endtask

  // Pulse reset between edges, leaving inputs idle.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    // Reset state, with requests present: no ready may leak out.
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    check_val("rst_a_ready", 64'(a_ready), 64'd0);
    check_val("rst_b_ready", 64'(b_ready), 64'd0);
    check_commit("rst", 1'b0, '0, '0);
    check_val("rst_byp1", 64'(byp1_hit), 64'd0);
    check_val("rst_byp1d", byp1_data, 64'd0);
    check_val("rst_cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    check_val("rst_hold_cnt", 64'(conflict_cnt), 64'd0);
    idle_inputs();
    #2;
    rst_n = 1'b1;

    // A alone: rd=3, data=0x55.
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h55; rs1 = 5'd3; rs2 = 5'd4;
    #1;
    check_val("t1_a_ready", 64'(a_ready), 64'd1);
    check_val("t1_b_ready", 64'(b_ready), 64'd0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check_commit("t1", 1'b1, 5'd3, 64'h55);
    check_val("t1_byp1_hit", 64'(byp1_hit), 64'd1);
    check_val("t1_byp1_data", byp1_data, 64'h55);
    check_val("t1_byp2_hit", 64'(byp2_hit), 64'd0);
    check_val("t1_byp2_data", byp2_data, 64'd0);
    @(negedge clk);
    #1;
    check_commit("t1_idle", 1'b0, '0, '0);

    // Continuous contention: A, B, A, B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_rd = 5'd1; a_data = 64'hA1;
      b_valid = 1'b1; b_rd = 5'd2; b_data = 64'hB2;
      #1;
      check_val($sformatf("t2_a_ready%0d", i), 64'(a_ready), 64'((i % 2) == 0));
      check_val($sformatf("t2_b_ready%0d", i), 64'(b_ready), 64'((i % 2) == 1));
      if (i > 0) begin
        if ((i % 2) == 1) check_commit($sformatf("t2_c%0d", i), 1'b1, 5'd1, 64'hA1);
        else              check_commit($sformatf("t2_c%0d", i), 1'b1, 5'd2, 64'hB2);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check_commit("t2_last", 1'b1, 5'd2, 64'hB2);
    check_val("t2_cnt", 64'(conflict_cnt), 64'd4);

    // B writes x0, then a tie goes to A since B won last.
    @(negedge clk);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 64'hFF;
    #1;
    check_val("t3_b_ready", 64'(b_ready), 64'd1);
    check_val("t3_a_ready", 64'(a_ready), 64'd0);
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h5A;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 64'h6B;
    rs1 = 5'd0;
    #1;
    check_commit("t3_x0", 1'b0, '0, '0);
    check_val("t3_x0_byp", 64'(byp1_hit), 64'd0);
    check_val("t3_tie_a", 64'(a_ready), 64'd1);
    check_val("t3_tie_b", 64'(b_ready), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_commit("t3_c", 1'b1, 5'd5, 64'h5A);
    check_val("t3_cnt", 64'(conflict_cnt), 64'd5);

    // Flush while both valid with a commit pending.
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h77;
    @(negedge clk);
    flush = 1'b1;
    a_valid = 1'b1; a_rd = 5'd8; a_data = 64'h88;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
    #1;
    check_commit("t4_pend", 1'b1, 5'd7, 64'h77);
    check_val("t4_fl_a", 64'(a_ready), 64'd0);
    check_val("t4_fl_b", 64'(b_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_commit("t4_clr", 1'b0, '0, '0);
    check_val("t4_cnt_fl", 64'(conflict_cnt), 64'd6);
    check_val("t4_tie_b", 64'(b_ready), 64'd1);
    check_val("t4_tie_a", 64'(a_ready), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_commit("t4_c", 1'b1, 5'd9, 64'h99);
    check_val("t4_cnt", 64'(conflict_cnt), 64'd7);

    // Asynchronous reset with a commit in flight.
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd10; a_data = 64'hAA;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check_commit("t5_pend", 1'b1, 5'd10, 64'hAA);
    rst_n = 1'b0;
    a_valid = 1'b1;
    #1;
    check_commit("t5_async", 1'b0, '0, '0);
    check_val("t5_cnt", 64'(conflict_cnt), 64'd0);
    check_val("t5_a_ready", 64'(a_ready), 64'd0);
    @(negedge clk);
    #1;
    check_commit("t5_held", 1'b0, '0, '0);
    rst_n = 1'b1;
    #1;
    check_val("t5_rel_a_ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_commit("t5_rel_c", 1'b1, 5'd10, 64'hAA);

    // Saturation of the 4-bit counter.
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd1; a_data = 64'h1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'h2;
    repeat (14) @(negedge clk);
    #1;
    check_val("t6_cnt14", 64'(conflict_cnt), 64'd14);
    repeat (6) @(negedge clk);
    #1;
    check_val("t6_cnt_sat", 64'(conflict_cnt), 64'd15);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
